// File: rtl/pipeline_pkg.sv
// Shared RV32I pipeline types and constants used by the fetch stage.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [6:0]  OPC_JAL    = 7'b1101111;
  localparam logic [6:0]  OPC_JALR   = 7'b1100111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_INSTR, valid: 1'b0};

endpackage

// File: rtl/fetch_redirect_unit_if_id_reg.sv
// IF/ID pipeline register: reset/flush load a NOP bubble, load captures, otherwise holds.
module if_id_reg
  import pipeline_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   i_load,
  input  logic   i_flush,
  input  if_id_t i_d,
  output if_id_t o_q
);

  if_id_t r_q;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_q <= IF_ID_BUBBLE;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_redirect_unit.sv
// PC register, next-PC selection and IF/ID register with EX-stage redirect and stall.
// Optional FETCH_PERF_CNT_EN adds fetch and redirect performance counters.
module fetch_redirect_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned IMEM_ADDR_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   br_taken,
  input  logic                   jmp,
  input  logic [31:0]            alu_target,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            if_id_pc,
  output logic [31:0]            if_id_instr,
  output logic                   if_id_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]            perf_fetch_cnt,
  output logic [31:0]            perf_redirect_cnt,
`endif
  output logic                   flush_id_ex
);

  logic [31:0] r_pc;
  logic        w_redirect;
  logic        w_advance;
  logic [31:0] w_target;
  logic        w_unused_tgt_lo;
  if_id_t      w_if_id_d;
  if_id_t      w_if_id_q;

  assign w_redirect      = br_taken | jmp;
  assign w_advance       = ~w_redirect & ~stall;
  assign w_target        = {alu_target[31:2], 2'b00};
  assign w_unused_tgt_lo = ^alu_target[1:0];

  // Redirect beats stall: the two younger instructions are squashed regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (!stall) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign w_if_id_d = '{pc: r_pc, instr: imem_rdata, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_advance),
    .i_flush (w_redirect),
    .i_d     (w_if_id_d),
    .o_q     (w_if_id_q)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_redirect_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch_cnt    <= '0;
      r_perf_redirect_cnt <= '0;
    end else begin
      if (w_advance)  r_perf_fetch_cnt    <= r_perf_fetch_cnt + 32'd1;
      if (w_redirect) r_perf_redirect_cnt <= r_perf_redirect_cnt + 32'd1;
    end
  end

  assign perf_fetch_cnt    = r_perf_fetch_cnt;
  assign perf_redirect_cnt = r_perf_redirect_cnt;
`endif

  assign imem_addr   = r_pc[IMEM_ADDR_W-1:0];
  assign if_id_pc    = w_if_id_q.pc;
  assign if_id_instr = w_if_id_q.instr;
  assign if_id_valid = w_if_id_q.valid;
  assign flush_id_ex = w_redirect & ~rst;

endmodule
